// File: rtl/prio_grant_sequencer_if.sv
// Bundle between the grant sequencer, its clients, the external arbiter and the beat sink.
interface prio_grant_sequencer_if #(
    parameter int SIZE   = 4,
    parameter int BEAT_W = 4
);
    localparam int ID_W = $clog2(SIZE);

    logic [SIZE-1:0]   req_pulse;
    logic [BEAT_W-1:0] beats;
    logic [SIZE-1:0]   arb_req;
    logic [SIZE-1:0]   arb_gnt;
    logic [SIZE-1:0]   pending;
    logic              gnt_valid;
    logic [SIZE-1:0]   gnt_onehot;
    logic [ID_W-1:0]   gnt_id;
    logic              beat_ready;
    logic              last;

    modport slave (
        input  req_pulse, beats, arb_gnt, beat_ready,
        output arb_req, pending, gnt_valid, gnt_onehot, gnt_id, last
    );

    modport master (
        output req_pulse, beats, arb_gnt, beat_ready,
        input  arb_req, pending, gnt_valid, gnt_onehot, gnt_id, last
    );
endinterface

// File: rtl/prio_grant_sequencer.sv
// Sticky request capture plus burst grant holder wrapped around an external MSB-first arbiter.
module prio_grant_sequencer #(
    parameter int SIZE   = 4,
    parameter int BEAT_W = 4
) (
    input  logic clk,
    input  logic rst,
    prio_grant_sequencer_if.slave bus
);
    localparam int ID_W = $clog2(SIZE);

    typedef enum logic [0:0] {
        IDLE_S  = 1'b0,
        BURST_S = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]   pending_q, pending_d;
    logic [SIZE-1:0]   gnt_onehot_q, gnt_onehot_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [SIZE-1:0]   clr_s;

    // OR of set-bit indices: exact for one-hot, and the "as-is" result for an illegal multi-hot grant.
    function automatic logic [ID_W-1:0] encode_f(input logic [SIZE-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (v[i]) begin
                r = r | ID_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // State, beat counter, latched grant and pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE_S;
            cnt_q        <= '0;
            pending_q    <= '0;
            gnt_onehot_q <= '0;
            gnt_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_id_q     <= gnt_id_d;
        end
    end

    // Next-state: arbitrate in IDLE, count accepted beats in BURST.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_id_d     = gnt_id_q;
        clr_s        = '0;
        case (state_q)
            IDLE_S: begin
                if (|bus.arb_gnt) begin
                    gnt_onehot_d = bus.arb_gnt;
                    gnt_id_d     = encode_f(bus.arb_gnt);
                    cnt_d        = bus.beats;
                    state_d      = BURST_S;
                end else begin
                    state_d = IDLE_S;
                end
            end
            BURST_S: begin
                if (bus.beat_ready) begin
                    if (cnt_q == '0) begin
                        clr_s        = gnt_onehot_q;
                        gnt_onehot_d = '0;
                        gnt_id_d     = '0;
                        state_d      = IDLE_S;
                    end else begin
                        cnt_d = cnt_q - BEAT_W'(1);
                    end
                end else begin
                    state_d = BURST_S;
                end
            end
            default: begin
                state_d      = IDLE_S;
                cnt_d        = '0;
                gnt_onehot_d = '0;
                gnt_id_d     = '0;
            end
        endcase
        // A fresh pulse beats the last-beat clear, so a re-request is never lost.
        pending_d = (pending_q & ~clr_s) | bus.req_pulse;
    end

    assign bus.pending    = pending_q;
    assign bus.arb_req    = (state_q == IDLE_S) ? pending_q : '0;
    assign bus.gnt_valid  = (state_q == BURST_S);
    assign bus.gnt_onehot = gnt_onehot_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.last       = (state_q == BURST_S) && (cnt_q == '0);

    prio_grant_sequencer_chk #(.SIZE(SIZE)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .gnt_onehot (gnt_onehot_q),
        .arb_gnt    (bus.arb_gnt),
        .arb_req    (bus.arb_req),
        .gnt_valid  (bus.gnt_valid),
        .in_burst   (state_q == BURST_S)
    );
endmodule

// Protocol checks on the grant holder and the arbiter it talks to.
module prio_grant_sequencer_chk #(
    parameter int SIZE = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [SIZE-1:0] gnt_onehot,
    input logic [SIZE-1:0] arb_gnt,
    input logic [SIZE-1:0] arb_req,
    input logic            gnt_valid,
    input logic            in_burst
);
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_onehot));
    a_valid_state: assert property (@(posedge clk) disable iff (rst) gnt_valid == in_burst);
    a_gnt_subset:  assert property (@(posedge clk) disable iff (rst) (arb_gnt & ~arb_req) == '0);
    a_arb_onehot:  assert property (@(posedge clk) disable iff (rst) !in_burst |-> $onehot0(arb_gnt));
endmodule

// File: tb/tb_prio_grant_sequencer.sv
// Scoreboard bench for prio_grant_sequencer with a behavioural MSB-first arbiter in the loop.
module tb_prio_grant_sequencer;
    localparam int SIZE   = 4;
    localparam int BEAT_W = 4;

    typedef struct {
        logic [1:0] id;
        logic [3:0] oh;
        logic       lst;
        int         gap;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   last_acc_cyc = -100;
    exp_t sb[$];

    prio_grant_sequencer_if #(.SIZE(SIZE), .BEAT_W(BEAT_W)) bus ();

    prio_grant_sequencer #(.SIZE(SIZE), .BEAT_W(BEAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External arbiter: highest-numbered requester wins.
    always_comb begin
        bus.arb_gnt = 4'b0000;
        for (int i = 0; i < SIZE; i++) begin
            if (bus.arb_req[i]) bus.arb_gnt = 4'b0001 << i;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_burst(input int id, input int nbeats, input int gap);
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            e.id  = 2'(id);
            e.oh  = 4'b0001 << id;
            e.lst = (b == nbeats - 1);
            e.gap = (b == 0) ? gap : -1;
            sb.push_back(e);
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        bus.req_pulse = v;
        @(posedge clk); #1;
        bus.req_pulse = 4'b0000;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!bus.gnt_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, {31'd0, bus.gnt_valid}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0 && !bus.gnt_valid) break;
            @(posedge clk); #1;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    // Monitor: every accepted beat is matched against the front of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst && bus.gnt_valid && bus.beat_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_beat", {28'd0, bus.gnt_onehot}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_id", {30'd0, bus.gnt_id}, {30'd0, e.id});
                chk("beat_onehot", {28'd0, bus.gnt_onehot}, {28'd0, e.oh});
                chk("beat_last", {31'd0, bus.last}, {31'd0, e.lst});
                if (e.gap >= 0) chk("idle_gap", cyc - last_acc_cyc, e.gap);
                if (e.lst) last_acc_cyc = cyc;
            end
        end
    end

    initial begin
        logic [6:0] pat;
        rst            = 1'b0;
        bus.req_pulse  = 4'b0000;
        bus.beats      = 4'd0;
        bus.beat_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bus.gnt_valid}, 32'd0);
        chk("rst_pending", {28'd0, bus.pending}, 32'd0);
        chk("rst_arb_req", {28'd0, bus.arb_req}, 32'd0);
        chk("rst_last", {31'd0, bus.last}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single pulse, three beats
        bus.beats = 4'd2;
        push_burst(1, 3, -1);
        pulse(4'b0010);
        chk("t1_pending", {28'd0, bus.pending}, 32'h2);
        chk("t1_not_yet", {31'd0, bus.gnt_valid}, 32'd0);
        chk("t1_arb_req", {28'd0, bus.arb_req}, 32'h2);
        @(posedge clk); #1;
        chk("t1_valid", {31'd0, bus.gnt_valid}, 32'd1);
        chk("t1_id", {30'd0, bus.gnt_id}, 32'd1);
        chk("t1_burst_arb_req", {28'd0, bus.arb_req}, 32'd0);
        wait_drain("t1_drain");
        chk("t1_pending_clr", {28'd0, bus.pending}, 32'd0);

        // 2: two simultaneous clients, MSB first, one idle cycle between
        bus.beats = 4'd0;
        push_burst(2, 1, -1);
        push_burst(0, 1, 2);
        pulse(4'b0101);
        chk("t2_pending", {28'd0, bus.pending}, 32'h5);
        wait_drain("t2_drain");
        chk("t2_pending_clr", {28'd0, bus.pending}, 32'd0);

        // 3: backpressure pattern 1,0,0,1,1,0,1
        bus.beats      = 4'd3;
        bus.beat_ready = 1'b0;
        push_burst(2, 4, -1);
        pulse(4'b0100);
        wait_valid("t3_valid");
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            bus.beat_ready = pat[i];
            @(posedge clk); #1;
        end
        bus.beat_ready = 1'b1;
        chk("t3_remaining", sb.size(), 32'd0);
        wait_drain("t3_drain");

        // 4: no preemption; beats change during burst is ignored
        bus.beats = 4'd5;
        push_burst(0, 6, -1);
        push_burst(3, 2, 2);
        pulse(4'b0001);
        wait_valid("t4_valid");
        bus.beats = 4'd1;
        @(posedge clk); #1;
        bus.req_pulse = 4'b1000;
        @(posedge clk); #1;
        bus.req_pulse = 4'b0000;
        chk("t4_pending", {28'd0, bus.pending}, 32'h9);
        chk("t4_arb_req", {28'd0, bus.arb_req}, 32'd0);
        chk("t4_id_held", {30'd0, bus.gnt_id}, 32'd0);
        wait_drain("t4_drain");
        chk("t4_pending_clr", {28'd0, bus.pending}, 32'd0);

        // 5: re-request on the last beat stays pending
        bus.beats = 4'd1;
        push_burst(1, 2, -1);
        push_burst(1, 2, 2);
        pulse(4'b0010);
        wait_valid("t5_valid");
        chk("t5_last_lo", {31'd0, bus.last}, 32'd0);
        @(posedge clk); #1;
        chk("t5_last_hi", {31'd0, bus.last}, 32'd1);
        bus.req_pulse = 4'b0010;
        @(posedge clk); #1;
        bus.req_pulse = 4'b0000;
        chk("t5_pending_kept", {28'd0, bus.pending}, 32'h2);
        chk("t5_idle", {31'd0, bus.gnt_valid}, 32'd0);
        wait_drain("t5_drain");
        chk("t5_pending_clr", {28'd0, bus.pending}, 32'd0);

        // 6: asynchronous reset mid-burst
        bus.beats = 4'd7;
        push_burst(3, 8, -1);
        pulse(4'b1000);
        wait_valid("t6_valid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, bus.gnt_valid}, 32'd0);
        chk("t6_onehot", {28'd0, bus.gnt_onehot}, 32'd0);
        chk("t6_id", {30'd0, bus.gnt_id}, 32'd0);
        chk("t6_last", {31'd0, bus.last}, 32'd0);
        chk("t6_pending", {28'd0, bus.pending}, 32'd0);
        chk("t6_arb_req", {28'd0, bus.arb_req}, 32'd0);
        chk("t6_beats_seen", sb.size(), 32'd6);
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_grant", {31'd0, bus.gnt_valid}, 32'd0);
        chk("t6_no_pending", {28'd0, bus.pending}, 32'd0);
        bus.beats = 4'd0;
        push_burst(2, 1, -1);
        pulse(4'b0100);
        wait_drain("t6_recover");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
